// File: rtl/stream_crossbar_pkg.sv
// Shared types and constants for the stream crossbar slave-side blocks.
package stream_crossbar_pkg;

   // Output-stage FSM: waiting for a grant, or locked onto one master for a packet.
   typedef enum logic {IDLE, LOCK} out_state_t;

   localparam int OUT_BUF_DEPTH = 2;
   localparam int OUT_BUF_CNT_W = $clog2(OUT_BUF_DEPTH + 1);

   // Master id width, identical to the formula used by round_robin_arbiter.
   function automatic int id_width(input int count);
      return $clog2(count);
   endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry FIFO with registered full flag. Entry 0 is always the head, so
// the head entry only changes on a pop or on a push into an empty buffer.
module stream_skid_buffer
   import stream_crossbar_pkg::*;
#(
   parameter int WIDTH = 10
)(
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic [OUT_BUF_CNT_W-1:0] count_o
);

   logic [WIDTH-1:0]         ent0_q, ent0_d;
   logic [WIDTH-1:0]         ent1_q, ent1_d;
   logic [OUT_BUF_CNT_W-1:0] count_q, count_d;
   logic                     full_q;
   logic                     do_push;
   logic                     do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && !full_q;

   // Next entries and occupancy for every push/pop combination.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10: begin
            if (count_q == '0) ent0_d = data_i;
            else               ent1_d = data_i;
            count_d = count_q + 1'b1;
         end
         2'b01: begin
            ent0_d  = ent1_q;
            count_d = count_q - 1'b1;
         end
         2'b11: begin
            if (count_q == OUT_BUF_CNT_W'(1)) begin
               ent0_d = data_i;
            end else begin
               ent0_d = ent1_q;
               ent1_d = data_i;
            end
         end
         default: ;
      endcase
   end

   // Storage, occupancy and the registered full flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: the two entries are reset as well, so the slave data port reads 0 after reset.
         ent0_q  <= '0;
         ent1_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register updating from pre-edge values.
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
         count_q <= count_d;
         full_q  <= (count_d == OUT_BUF_CNT_W'(OUT_BUF_DEPTH));
      end
   end

   assign data_o  = ent0_q;
   assign full_o  = full_q;
   assign count_o = count_q;

endmodule

// File: rtl/stream_output_mux.sv
// Per-slave output stage: locks onto the granted master for a whole packet,
// routes its beats into a 2-entry buffer and returns a one-hot last pulse.
module stream_output_mux
   import stream_crossbar_pkg::*;
#(
   parameter  int S_DATA_COUNT = 2,
   parameter  int T_DATA_WIDTH = 8,
   localparam int T_ID___WIDTH = id_width(S_DATA_COUNT)
)(
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic                                     grant_valid_i,
   input  logic [T_ID___WIDTH-1:0]                  grant_id_i,
   input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] s_tdata_i,
   input  logic [S_DATA_COUNT-1:0]                  s_tvalid_i,
   input  logic [S_DATA_COUNT-1:0]                  s_tlast_i,
   output logic [S_DATA_COUNT-1:0]                  s_tready_o,
   output logic [T_DATA_WIDTH-1:0]                  m_tdata_o,
   output logic [T_ID___WIDTH-1:0]                  m_tid_o,
   output logic                                     m_tlast_o,
   output logic                                     m_tvalid_o,
   input  logic                                     m_tready_i,
   output logic [S_DATA_COUNT-1:0]                  last_o
);

   localparam int BUF_W = T_DATA_WIDTH + T_ID___WIDTH + 1;

   out_state_t                state_q, state_d;
   logic [T_ID___WIDTH-1:0]   lock_id_q, lock_id_d;
   logic                      buf_push;
   logic                      buf_full;
   logic [BUF_W-1:0]          buf_wdata;
   logic [BUF_W-1:0]          buf_head;
   logic [OUT_BUF_CNT_W-1:0]  buf_count;

   // Beat written into the buffer always comes from the locked master.
   assign buf_wdata = {s_tdata_i[lock_id_q], lock_id_q, s_tlast_i[lock_id_q]};

   // Next state, lock id, per-master ready, push strobe and last pulse.
   always_comb begin
      state_d    = state_q;
      lock_id_d  = lock_id_q;
      s_tready_o = '0;
      last_o     = '0;
      buf_push   = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_valid_i) begin
               lock_id_d = grant_id_i;
               state_d   = LOCK;
            end
         end
         LOCK: begin
            s_tready_o[lock_id_q] = !buf_full;
            if (s_tvalid_i[lock_id_q] && !buf_full) begin
               buf_push = 1'b1;
               if (s_tlast_i[lock_id_q]) begin
                  last_o[lock_id_q] = 1'b1;
                  state_d           = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state and locked master id.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         lock_id_q <= '0;
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
      end
   end

   stream_skid_buffer #(
      .WIDTH (BUF_W)
   ) u_out_buf (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (buf_push),
      .data_i  (buf_wdata),
      .pop_i   (m_tready_i),
      .data_o  (buf_head),
      .full_o  (buf_full),
      .count_o (buf_count)
   );

   assign {m_tdata_o, m_tid_o, m_tlast_o} = buf_head;
   assign m_tvalid_o = (buf_count != '0);

endmodule

// File: tb/tb_stream_output_mux.sv
// Self-checking bench for stream_output_mux: directed scenarios plus a
// randomized phase, all scored against a queue-based packet model.
module tb_stream_output_mux;

   localparam int S  = 2;
   localparam int W  = 8;
   localparam int IW = 1;

   logic                clk_i = 1'b0;
   logic                rst_i;
   logic                grant_valid_i;
   logic [IW-1:0]       grant_id_i;
   logic [S-1:0][W-1:0] s_tdata_i;
   logic [S-1:0]        s_tvalid_i;
   logic [S-1:0]        s_tlast_i;
   logic [S-1:0]        s_tready_o;
   logic [W-1:0]        m_tdata_o;
   logic [IW-1:0]       m_tid_o;
   logic                m_tlast_o;
   logic                m_tvalid_o;
   logic                m_tready_i;
   logic [S-1:0]        last_o;

   typedef struct packed {
      logic [W-1:0]  data;
      logic [IW-1:0] id;
      logic          last;
   } beat_t;

   // Reference model: a queue of beats the slave port still owes, plus lock status.
   beat_t         exp_q[$];
   bit            mdl_locked;
   logic [IW-1:0] mdl_id;
   bit            mdl_fresh;

   int n_cmp  = 0;
   int n_bad  = 0;
   int cyc_no = 0;

   // What happened in the most recent cycle, for the stimulus loops.
   bit            cyc_acc, cyc_acc_last, cyc_pop;
   logic [IW-1:0] cyc_acc_id, cyc_pop_id;

   // Per-master packet source state.
   int         beat [S];
   int         len  [S];
   logic [7:0] base [S];
   bit         en   [S];
   bit         vgate[S];

   always #5 clk_i = ~clk_i;

   stream_output_mux #(
      .S_DATA_COUNT (S),
      .T_DATA_WIDTH (W)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .grant_valid_i (grant_valid_i),
      .grant_id_i    (grant_id_i),
      .s_tdata_i     (s_tdata_i),
      .s_tvalid_i    (s_tvalid_i),
      .s_tlast_i     (s_tlast_i),
      .s_tready_o    (s_tready_o),
      .m_tdata_o     (m_tdata_o),
      .m_tid_o       (m_tid_o),
      .m_tlast_o     (m_tlast_o),
      .m_tvalid_o    (m_tvalid_o),
      .m_tready_i    (m_tready_i),
      .last_o        (last_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc_no, got, exp);
      end
   endtask

   // One clock cycle: compare DUT outputs with the model mid-cycle, then advance the model.
   task automatic step();
      logic [S-1:0] exp_rdy;
      logic [S-1:0] exp_last;
      bit           acc, acc_last, pop;
      beat_t        b, dropped;
      @(negedge clk_i);
      exp_rdy  = '0;
      exp_last = '0;
      acc      = 1'b0;
      if (mdl_locked && exp_q.size() < 2) begin
         exp_rdy[mdl_id] = 1'b1;
         acc             = s_tvalid_i[mdl_id];
      end
      acc_last = acc && s_tlast_i[mdl_id];
      if (acc_last) exp_last[mdl_id] = 1'b1;
      pop = (exp_q.size() != 0) && m_tready_i;
      check("s_tready", s_tready_o, exp_rdy);
      check("m_tvalid", m_tvalid_o, exp_q.size() != 0);
      check("last_o", last_o, exp_last);
      if (exp_q.size() != 0)
         check("m_beat", {m_tdata_o, m_tid_o, m_tlast_o}, exp_q[0]);
      else if (mdl_fresh)
         check("m_zero", {m_tdata_o, m_tid_o, m_tlast_o}, 0);
      cyc_pop_id = (exp_q.size() != 0) ? exp_q[0].id : '0;
      @(posedge clk_i);
      #1;
      cyc_no++;
      cyc_acc      = acc;
      cyc_acc_last = acc_last;
      cyc_acc_id   = mdl_id;
      cyc_pop      = pop;
      if (rst_i) begin
         exp_q.delete();
         mdl_locked   = 1'b0;
         mdl_fresh    = 1'b1;
         cyc_acc      = 1'b0;
         cyc_acc_last = 1'b0;
         cyc_pop      = 1'b0;
      end else begin
         if (pop) dropped = exp_q.pop_front();
         if (acc) begin
            b.data = s_tdata_i[mdl_id];
            b.id   = mdl_id;
            b.last = s_tlast_i[mdl_id];
            exp_q.push_back(b);
            mdl_fresh = 1'b0;
         end
         if (mdl_locked) begin
            if (acc_last) mdl_locked = 1'b0;
         end else if (grant_valid_i) begin
            mdl_locked = 1'b1;
            mdl_id     = grant_id_i;
         end
      end
   endtask

   task automatic load(input int m, input int n, input logic [7:0] b);
      beat[m] = 0;
      len[m]  = n;
      base[m] = b;
   endtask

   // Drive the masters, run one cycle, advance sources.
   // mode 0: fixed packets; 1: endless 3-beat packets; 2: random lengths and valid gaps.
   task automatic cycle(input int mode);
      for (int m = 0; m < S; m++) begin
         s_tvalid_i[m] = en[m] && vgate[m] && (beat[m] < len[m]);
         s_tdata_i[m]  = base[m] + 8'(beat[m]);
         s_tlast_i[m]  = (beat[m] == len[m] - 1);
      end
      step();
      if (cyc_acc) beat[cyc_acc_id]++;
      for (int m = 0; m < S; m++) begin
         if (mode != 0 && beat[m] >= len[m])
            load(m, (mode == 1) ? 3 : int'($urandom_range(4, 1)), 8'($urandom));
         if (!vgate[m] || (cyc_acc && int'(cyc_acc_id) == m))
            vgate[m] = (mode == 2) ? ($urandom_range(3) != 0) : 1'b1;
      end
   endtask

   task automatic drain();
      grant_valid_i = 1'b0;
      m_tready_i    = 1'b1;
      for (int m = 0; m < S; m++) en[m] = 1'b0;
      for (int i = 0; i < 8; i++) cycle(0);
      check("drain_tvalid", m_tvalid_o, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int            last_cyc, first_out, n_out, n_acc, acc0, n0, n0_at1, last0, first1;
      int            last_acc_cyc, mode;
      bit            prev_last, have_prev;
      logic [IW-1:0] prev_id;

      rst_i         = 1'b1;
      grant_valid_i = 1'b0;
      grant_id_i    = '0;
      s_tdata_i     = '0;
      s_tvalid_i    = '0;
      s_tlast_i     = '0;
      m_tready_i    = 1'b0;
      for (int m = 0; m < S; m++) begin
         en[m] = 1'b0; vgate[m] = 1'b1; beat[m] = 0; len[m] = 0; base[m] = '0;
      end

      // Reset held for 3 cycles, then idle with no grant.
      @(posedge clk_i);
      #1;
      exp_q.delete();
      mdl_locked = 1'b0;
      mdl_fresh  = 1'b1;
      mdl_id     = '0;
      repeat (2) step();
      rst_i = 1'b0;
      for (int i = 0; i < 5; i++) cycle(0);

      // Single 4-beat packet from master 1, slave always ready.
      m_tready_i = 1'b1;
      load(1, 4, 8'hA0);
      en[1]         = 1'b1;
      grant_valid_i = 1'b1;
      grant_id_i    = 1'b1;
      last_cyc = -1; first_out = -1; n_out = 0;
      for (int c = 0; c < 8; c++) begin
         cycle(0);
         grant_valid_i = 1'b0;
         if (cyc_acc_last) last_cyc = c;
         if (cyc_pop) begin
            if (first_out < 0) first_out = c;
            n_out++;
         end
      end
      check("single_last_cycle", last_cyc, 4);
      check("single_first_out", first_out, 2);
      check("single_beats", n_out, 4);
      drain();

      // Backpressure: slave stalled, only two beats may enter.
      m_tready_i = 1'b0;
      load(1, 4, 8'hA0);
      en[1]         = 1'b1;
      grant_valid_i = 1'b1;
      grant_id_i    = 1'b1;
      n_acc = 0; n_out = 0;
      for (int c = 0; c < 7; c++) begin
         cycle(0);
         grant_valid_i = 1'b0;
         if (cyc_acc) n_acc++;
      end
      check("bp_accepts", n_acc, 2);
      check("bp_ready_low", s_tready_o, 0);
      m_tready_i = 1'b1;
      for (int c = 0; c < 10; c++) begin
         cycle(0);
         if (cyc_pop) n_out++;
      end
      check("bp_delivered", n_out, 4);
      drain();

      // Grant moves to master 1 after beat 2 of master 0's 5-beat packet.
      load(0, 5, 8'h50);
      load(1, 2, 8'hB0);
      en[0] = 1'b1; en[1] = 1'b1;
      m_tready_i    = 1'b1;
      grant_valid_i = 1'b1;
      grant_id_i    = 1'b0;
      acc0 = 0; n0 = 0; n0_at1 = -1; last0 = -1; first1 = -1;
      for (int c = 0; c < 14; c++) begin
         cycle(0);
         if (cyc_acc && cyc_acc_id == 1'b0) acc0++;
         if (acc0 >= 2) grant_id_i = 1'b1;
         if (cyc_acc_last && cyc_acc_id == 1'b0) last0 = c;
         if (cyc_acc && cyc_acc_id == 1'b1 && first1 < 0) first1 = c;
         if (cyc_acc_last && cyc_acc_id == 1'b1) grant_valid_i = 1'b0;
         if (cyc_pop) begin
            if (cyc_pop_id == 1'b0) n0++;
            else if (n0_at1 < 0) n0_at1 = n0;
         end
      end
      check("gc_m0_beats_first", n0_at1, 5);
      check("gc_idle_gap", first1 - last0, 2);
      drain();

      // Reset with two beats buffered, then a fresh grant.
      load(0, 4, 8'h70);
      en[0]         = 1'b1;
      m_tready_i    = 1'b0;
      grant_valid_i = 1'b1;
      grant_id_i    = 1'b0;
      for (int c = 0; c < 3; c++) cycle(0);
      rst_i = 1'b1;
      cycle(0);
      rst_i         = 1'b0;
      grant_valid_i = 1'b0;
      en[0]         = 1'b0;
      check("rst_tvalid", m_tvalid_o, 0);
      check("rst_tready", s_tready_o, 0);
      cycle(0);
      load(1, 2, 8'hC0);
      en[1]         = 1'b1;
      m_tready_i    = 1'b1;
      grant_valid_i = 1'b1;
      grant_id_i    = 1'b1;
      n_out = 0;
      for (int c = 0; c < 6; c++) begin
         cycle(0);
         grant_valid_i = 1'b0;
         if (cyc_pop) n_out++;
      end
      check("rst_then_beats", n_out, 2);
      drain();

      // Round-robin arbiter stand-in: both masters always requesting,
      // 3-beat packets first, then random lengths, valid gaps and backpressure.
      load(0, 3, 8'h10);
      load(1, 3, 8'h20);
      en[0] = 1'b1; en[1] = 1'b1;
      m_tready_i    = 1'b1;
      grant_valid_i = 1'b1;
      grant_id_i    = 1'b0;
      have_prev = 1'b0; prev_last = 1'b0; prev_id = '0; last_acc_cyc = 0;
      for (int c = 0; c < 2040; c++) begin
         mode = (c < 40) ? 1 : 2;
         if (mode == 2) m_tready_i = ($urandom_range(3) != 0);
         cycle(mode);
         if (cyc_acc) begin
            if (prev_last) begin
               if (mode == 1) check("pkt_gap", cyc_no - last_acc_cyc, 2);
               else           check("pkt_gap_min", (cyc_no - last_acc_cyc) >= 2, 1);
            end
            prev_last    = cyc_acc_last;
            last_acc_cyc = cyc_no;
         end
         if (cyc_acc_last) begin
            if (have_prev) check("rr_alternate", cyc_acc_id, prev_id ^ 1'b1);
            prev_id    = cyc_acc_id;
            have_prev  = 1'b1;
            grant_id_i = cyc_acc_id + 1'b1;
         end
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/stream_output_mux.md
# stream_output_mux

Per-slave output stage of the stream crossbar, sitting directly downstream of `round_robin_arbiter`. It takes the arbiter's grant (`id_o` / `ready_o`), locks onto the granted master for one whole packet, and routes that master's AXI-Stream beats to the slave port through a 2-entry output buffer. On the accepted `tlast` beat it returns a one-hot last vector to the arbiter's `last_i`, which releases the grant.

## Interface
Parameters:
- `S_DATA_COUNT`, 2: number of masters (inputs); must be ≥ 2.
- `T_DATA_WIDTH`, 8: tdata width in bits.
- `T_ID___WIDTH`, localparam `$clog2(S_DATA_COUNT)`: master id width.

Ports:
- `clk_i` in 1: clock. One clock domain only.
- `rst_i` in 1: reset, synchronous, active-high.
- `grant_valid_i` in 1: grant present; driven by arbiter `ready_o`.
- `grant_id_i` in `T_ID___WIDTH`: granted master; driven by arbiter `id_o`.
- `s_tdata_i` in `[S_DATA_COUNT][T_DATA_WIDTH]`: per-master data.
- `s_tvalid_i` in `S_DATA_COUNT`: per-master valid.
- `s_tlast_i` in `S_DATA_COUNT`: per-master last.
- `s_tready_o` out `S_DATA_COUNT`: per-master ready; at most one bit set.
- `m_tdata_o` out `T_DATA_WIDTH`: slave data.
- `m_tid_o` out `T_ID___WIDTH`: source master of the current output beat.
- `m_tlast_o` out 1: slave last.
- `m_tvalid_o` out 1: slave valid.
- `m_tready_i` in 1: slave ready.
- `last_o` out `S_DATA_COUNT`: one-hot pulse for the accepted tlast beat; drives arbiter `last_i`.

## Operation
- FSM states are `IDLE` and `LOCK`. Registers:
  - `lock_id_q`: the locked master.
  - Buffer storage: `count_q` (0..2) plus 2 entries of {data, id, last}.
- **`IDLE`**:
  - `s_tready_o` = 0.
  - If `grant_valid_i` = 1, latch `lock_id_q <= grant_id_i` and go to `LOCK`.
- **`LOCK`**:
  - `s_tready_o[lock_id_q]` = `!full_q`, where `full_q` is registered `count_q==2`. All other ready bits are 0.
  - An input beat is accepted when `s_tvalid_i[lock_id_q] && s_tready_o[lock_id_q]`. The buffer is written with {`s_tdata_i[lock_id_q]`, `lock_id_q`, `s_tlast_i[lock_id_q]`}.
  - If the accepted beat has last = 1:
    - `last_o` = `1 << lock_id_q` combinationally in the same cycle; otherwise `last_o` = 0.
    - Next state is `IDLE`.
  - `grant_valid_i` and `grant_id_i` are ignored while in `LOCK`; a grant change mid-packet has no effect.
- `s_tvalid_i` of non-locked masters is ignored.
- **Output buffer (2-entry FIFO)**:
  - `m_tvalid_o` = `count_q != 0`; `m_*` show the head entry.
  - Pop on `m_tvalid_o && m_tready_i`.
  - Simultaneous push and pop leaves `count_q` unchanged.
  - Entries never change while `m_tvalid_o && !m_tready_i`, per AXI-Stream stability.
- **Reset**, including mid-packet:
  - State goes to `IDLE`, `count_q` = 0, buffered beats are discarded.
  - All outputs = 0: `s_tready_o`, `m_tvalid_o`, `m_tdata_o`, `m_tid_o`, `m_tlast_o`, `last_o`.

## Timing
- Grant-to-ready: `grant_valid_i` sampled high at edge N puts the block in `LOCK` from N+1; the first input accept is possible in cycle N+1.
- Input-to-output latency: a beat accepted in cycle N is visible on `m_*` in cycle N+1.
- Throughput: 1 beat/cycle inside a packet while `m_tready_i` = 1.
- Packet gap: one `IDLE` cycle after the accepted tlast. The arbiter's updated `id_o` is valid in that cycle.
- Back-to-back grants to the same master work unchanged.
- Backpressure: with `m_tready_i` = 0, exactly 2 beats are accepted. `s_tready_o` then drops on the cycle after the second push, because `full_q` is registered.
- Single-beat packet (tlast on first beat): `LOCK` lasts exactly one accepting cycle.
- `last_o` is never asserted in `IDLE`, and never for a beat that is not accepted.

## Structure
- Shared package `stream_crossbar_pkg` holds:
  - `typedef enum logic {IDLE, LOCK} out_state_t`
  - `localparam OUT_BUF_DEPTH = 2`
- The id width formula is shared with the arbiter.
- Sub-module `stream_skid_buffer` (2-entry FIFO, push/pop/full/count, `T_DATA_WIDTH + T_ID___WIDTH + 1` wide) is natural and is reused by the crossbar input side.
- The top level holds only the FSM, the `lock_id_q` register and the input mux.

## Test plan
- **Reset/idle:** hold `rst_i`=1 for 3 cycles, then release with `grant_valid_i`=0 → all outputs 0 and `s_tready_o`=2'b00 indefinitely.
- **Single packet:** grant id 1 at cycle 0; master 1 sends 4 beats (0xA0..0xA3, last on 0xA3) with `m_tready_i`=1 →
  - `s_tready_o`=2'b10 from cycle 1;
  - `m_tdata_o` = 0xA0..0xA3 in cycles 2..5 with `m_tid_o`=1;
  - `last_o`=2'b10 in cycle 4 only;
  - state `IDLE` in cycle 5.
- **Backpressure:** as above with `m_tready_i`=0 → exactly 2 beats accepted, `s_tready_o[1]` drops, `m_tdata_o`=0xA0 held stable. Releasing `m_tready_i` → remaining beats delivered in order, none lost or duplicated.
- **Grant change mid-packet:** `grant_id_i` switches 0→1 after beat 2 of a 5-beat packet from master 0 → all 5 beats delivered with `m_tid_o`=0; master 1 is served only after `last_o`=2'b01 and one `IDLE` cycle.
- **Reset mid-packet:** assert `rst_i` with 2 beats buffered → next cycle `m_tvalid_o`=0, `s_tready_o`=0, `last_o`=0; a new grant afterwards works normally.
- **Integration with `round_robin_arbiter`:** masters 0 and 1 both request continuously, 3-beat packets → output `m_tid_o` alternates 0,1,0,1 per packet with one idle cycle between packets.
